val2_shift_unit: RTL and testbench
==================================

VAL2_SHIFT_UNIT -- requirements
Module: val2_shift_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 Parameter REG_SHIFT_EN, default 1, enables register-specified shifts.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  unit accepts the request this cycle.
REQ-008 val_rm  in  DATA_W  Rm value.
REQ-009 val_rs  in  DATA_W  Rs value; only bits [7:0] are used.
REQ-010 imm  in  1  32-bit-immediate form (I bit).
REQ-011 is_ldr_or_str  in  1  memory-offset form.
REQ-012 shift_operand  in  12  instruction bits [11:0].
REQ-013 c_in  in  1  current C flag.
REQ-014 tag_in  in  TAG_W  sideband, returned unchanged.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 val2_out  out  DATA_W  operand-2 result.
REQ-018 carry_out  out  1  shifter carry.
REQ-019 illegal  out  1  the request was an unsupported form.
REQ-020 tag_out  out  TAG_W  tag of the result.

Function
REQ-021 A request is accepted on a rising edge when in_valid and in_ready are both 1; a result retires on a rising edge when out_valid and out_ready are both 1.
REQ-022 Results are held in a 2-entry in-order buffer; in_ready is registered and equals (occupancy < 2); with an empty buffer the result appears one cycle after acceptance.
REQ-023 Simultaneous accept and retire leaves occupancy unchanged; at occupancy 2 no request is accepted, even if out_ready is 1 in that cycle.
REQ-024 While out_valid=1 and out_ready=0, val2_out, carry_out, illegal and tag_out are held stable.
REQ-025 Decode priority: is_ldr_or_str, then imm, then shift_operand[4]=0 (immediate shift), then register shift.
REQ-026 Memory offset: val2_out is shift_operand sign-extended from bit 11; carry_out = c_in.
REQ-027 Rotated immediate: the zero-extended byte [7:0] is rotated right by 2*[11:8] within DATA_W; carry_out = c_in when the rotate is 0, otherwise the result MSB.
REQ-028 Immediate shift, amount = [11:7], type = [6:5]: LSL #0 -> Rm with carry c_in; LSR #0 -> LSR by DATA_W; ASR #0 -> ASR by DATA_W; ROR #0 -> RRX = {c_in, Rm[DATA_W-1:1]} with carry Rm[0].
REQ-029 Register shift, amount = val_rs[7:0]; amount 0 gives Rm with carry c_in for every type.
REQ-030 LSL/LSR by amount n: 0 < n < DATA_W is a normal shift with carry equal to the last bit shifted out; n = DATA_W gives 0 with carry Rm[0] (LSL) or Rm[MSB] (LSR); n > DATA_W gives 0 with carry 0.
REQ-031 ASR by n >= DATA_W gives all bits equal to Rm[MSB] with carry Rm[MSB].
REQ-032 Register ROR: when n mod DATA_W = 0 and n != 0, the result is Rm with carry Rm[MSB]; otherwise the rotate amount is n mod DATA_W.
REQ-033 When shift_operand[7]=1 and shift_operand[4]=1 on the register path, or the register form is requested with REG_SHIFT_EN=0, the result is illegal=1, val2_out=0 and carry_out=c_in; this result still occupies a buffer slot.

Reset
REQ-034 While rst_n=0 at a clock edge: occupancy clears to 0, in_ready=0, out_valid=0, and val2_out, carry_out, illegal and tag_out are all 0.
REQ-035 in_ready rises on the first edge after rst_n returns to 1; results in flight when reset is asserted are discarded.

Structure
REQ-036 Package val2_pkg holds the form enum (MEM_OFF, IMM_ROT, IMM_SHIFT, REG_SHIFT), the shift-type enum (LSL, LSR, ASR, ROR) and the field-position constants.
REQ-037 A single combinational sub-module, val2_shift_core, performs decode, shift and carry; val2_shift_unit adds the handshake and the 2-entry buffer.

Verification
REQ-038 LSR #0 with Rm=0x8000_0001 -> val2_out=0, carry_out=1.
REQ-039 RRX with c_in=1, Rm=0x0000_0003 -> val2_out=0x8000_0001, carry_out=1.
REQ-040 Register LSL with Rs=32, Rm=0x0000_0001 -> 0, carry 1; with Rs=33 -> 0, carry 0; register ROR with Rs=64, Rm=0x8000_0000 -> Rm unchanged, carry 1.
REQ-041 imm=1, shift_operand=0x4FF -> 0xFF00_0000, carry 1; is_ldr_or_str=1, shift_operand=0x800 -> 0xFFFF_F800, carry=c_in.
REQ-042 out_ready held 0 while three requests are presented -> two are accepted, in_ready=0 on the next edge, outputs held stable; out_ready then 1 -> results retire in order with tags matching.
REQ-043 rst_n pulled low for one edge with occupancy 2 -> out_valid=0 and outputs 0 on that edge, in_ready=1 one edge after release, no stale result ever appears.

Source files
------------

// File: rtl/val2_shift_unit_pkg.sv
// Shared types and instruction field positions for the operand-2 shifter.
package val2_pkg;

  typedef enum logic [1:0] {MEM_OFF, IMM_ROT, IMM_SHIFT, REG_SHIFT} form_e;
  typedef enum logic [1:0] {LSL, LSR, ASR, ROR} shift_e;

  localparam int unsigned SO_W         = 12;
  localparam int unsigned MEM_SIGN_BIT = 11;
  localparam int unsigned ROT_HI       = 11;
  localparam int unsigned ROT_LO       = 8;
  localparam int unsigned IMM8_HI      = 7;
  localparam int unsigned SAMT_HI      = 11;
  localparam int unsigned SAMT_LO      = 7;
  localparam int unsigned STYPE_HI     = 6;
  localparam int unsigned STYPE_LO     = 5;
  localparam int unsigned REG_FORM_BIT = 4;
  localparam int unsigned REG_RSVD_BIT = 7;
  localparam int unsigned RS_AMT_W     = 8;

endpackage

// File: rtl/val2_shift_unit_if.sv
// Request/result handshake bundle between a requester and the shift unit.
interface val2_shift_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val_rs;
  logic              imm;
  logic              is_ldr_or_str;
  logic [11:0]       shift_operand;
  logic              c_in;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val2_out;
  logic              carry_out;
  logic              illegal;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, val_rm, val_rs, imm, is_ldr_or_str, shift_operand, c_in, tag_in, out_ready,
    input  in_ready, out_valid, val2_out, carry_out, illegal, tag_out
  );

  modport slave (
    input  in_valid, val_rm, val_rs, imm, is_ldr_or_str, shift_operand, c_in, tag_in, out_ready,
    output in_ready, out_valid, val2_out, carry_out, illegal, tag_out
  );
endinterface

// File: rtl/val2_shift_unit_core.sv
// Combinational decode, shift and carry generation for the operand-2 value.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter bit          REG_SHIFT_EN = 1'b1
) (
  input  logic [DATA_W-1:0]   rm_i,
  input  logic [RS_AMT_W-1:0] rs_amt_i,
  input  logic                imm_i,
  input  logic                is_mem_i,
  input  logic [SO_W-1:0]     so_i,
  input  logic                c_in_i,
  output logic [DATA_W-1:0]   val2_o,
  output logic                carry_o,
  output logic                illegal_o
);

  // Register-style shift semantics; returns {carry, result}. Amount 0 passes Rm through.
  function automatic logic [DATA_W:0] shift_fn(shift_e t, int unsigned n,
                                               logic [DATA_W-1:0] x, logic c);
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] t1;
    logic              co;
    int unsigned       m;
    r  = x;
    co = c;
    t1 = '0;
    m  = n % DATA_W;
    if (n != 0) begin
      case (t)
        LSL: begin
          if (n < DATA_W) begin
            r  = x << n;
            t1 = x >> (DATA_W - n);
            co = t1[0];
          end else begin
            r  = '0;
            co = (n == DATA_W) ? x[0] : 1'b0;
          end
        end
        LSR: begin
          if (n < DATA_W) begin
            r  = x >> n;
            t1 = x >> (n - 1);
            co = t1[0];
          end else begin
            r  = '0;
            co = (n == DATA_W) ? x[DATA_W-1] : 1'b0;
          end
        end
        ASR: begin
          if (n < DATA_W) begin
            r  = DATA_W'($signed(x) >>> n);
            t1 = x >> (n - 1);
            co = t1[0];
          end else begin
            r  = {DATA_W{x[DATA_W-1]}};
            co = x[DATA_W-1];
          end
        end
        ROR: begin
          if (m == 0) begin
            co = x[DATA_W-1];
          end else begin
            r  = (x >> m) | (x << (DATA_W - m));
            co = r[DATA_W-1];
          end
        end
      endcase
    end
    return {co, r};
  endfunction

  form_e       form_c;
  shift_e      typ_c;
  int unsigned amt_c;

  always_comb begin
    val2_o    = '0;
    carry_o   = c_in_i;
    illegal_o = 1'b0;
    amt_c     = 0;
    typ_c     = shift_e'(so_i[STYPE_HI:STYPE_LO]);
    if (is_mem_i)                form_c = MEM_OFF;
    else if (imm_i)              form_c = IMM_ROT;
    else if (!so_i[REG_FORM_BIT]) form_c = IMM_SHIFT;
    else                         form_c = REG_SHIFT;

    case (form_c)
      MEM_OFF: val2_o = {{(DATA_W-SO_W){so_i[MEM_SIGN_BIT]}}, so_i};
      IMM_ROT: begin
        amt_c = 32'(so_i[ROT_HI:ROT_LO]) << 1;
        {carry_o, val2_o} = shift_fn(ROR, amt_c, DATA_W'(so_i[IMM8_HI:0]), c_in_i);
      end
      IMM_SHIFT: begin
        amt_c = 32'(so_i[SAMT_HI:SAMT_LO]);
        if (amt_c == 0 && typ_c == ROR) begin
          // RRX: rotate through carry by one
          val2_o  = {c_in_i, rm_i[DATA_W-1:1]};
          carry_o = rm_i[0];
        end else begin
          if (amt_c == 0 && typ_c != LSL) amt_c = DATA_W;
          {carry_o, val2_o} = shift_fn(typ_c, amt_c, rm_i, c_in_i);
        end
      end
      REG_SHIFT: begin
        if (so_i[REG_RSVD_BIT] || !REG_SHIFT_EN) begin
          illegal_o = 1'b1;
        end else begin
          amt_c = 32'(rs_amt_i);
          {carry_o, val2_o} = shift_fn(typ_c, amt_c, rm_i, c_in_i);
        end
      end
    endcase
  end

endmodule

// File: rtl/val2_shift_unit.sv
// Operand-2 shift unit: valid/ready wrapper with a 2-entry in-order result buffer.
module val2_shift_unit
  import val2_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TAG_W        = 4,
  parameter bit          REG_SHIFT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  val2_shift_unit_if.slave bus
);

  localparam int unsigned ENT_W = DATA_W + 2 + TAG_W;

  logic [DATA_W-1:0] val2_c;
  logic              carry_c;
  logic              illegal_c;
  logic              unused_rs_hi;

  assign unused_rs_hi = ^bus.val_rs[DATA_W-1:RS_AMT_W];

  val2_shift_core #(.DATA_W(DATA_W), .REG_SHIFT_EN(REG_SHIFT_EN)) u_core (
    .rm_i      (bus.val_rm),
    .rs_amt_i  (bus.val_rs[RS_AMT_W-1:0]),
    .imm_i     (bus.imm),
    .is_mem_i  (bus.is_ldr_or_str),
    .so_i      (bus.shift_operand),
    .c_in_i    (bus.c_in),
    .val2_o    (val2_c),
    .carry_o   (carry_c),
    .illegal_o (illegal_c)
  );

  // Slot 0 is the head and drives the outputs directly; slot 1 queues behind it.
  logic [ENT_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic             in_ready_q, in_ready_d;
  logic             acc_c, ret_c;

  always_comb begin
    acc_c      = bus.in_valid & in_ready_q;
    ret_c      = v0_q & bus.out_ready;
    v0_d       = ret_c ? v1_q : v0_q;
    e0_d       = ret_c ? e1_q : e0_q;
    v1_d       = ret_c ? 1'b0 : v1_q;
    e1_d       = e1_q;
    if (acc_c) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        e0_d = {val2_c, carry_c, illegal_c, bus.tag_in};
      end else begin
        v1_d = 1'b1;
        e1_d = {val2_c, carry_c, illegal_c, bus.tag_in};
      end
    end
    in_ready_d = ~v1_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = v0_q;
  assign {bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} = e0_q;

endmodule

// File: tb/tb_val2_shift_unit.sv
// Self-checking bench for val2_shift_unit against a bit-serial reference model.
module tb_val2_shift_unit;

  typedef struct packed {
    logic [31:0] v;
    logic        c;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        imm;
    logic        mem;
    logic [11:0] so;
    logic        c;
    logic [31:0] ev;
    logic        ec;
    logic        eill;
  } dvec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  val2_shift_unit_if #(.DATA_W(32), .TAG_W(4)) bus ();

  val2_shift_unit #(.DATA_W(32), .TAG_W(4), .REG_SHIFT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit position per iteration, carry = last bit shifted out.
  function automatic logic [32:0] bitshift(int t, int n, logic [31:0] rm, logic c);
    logic [31:0] x;
    logic        cc;
    x  = rm;
    cc = c;
    case (t)
      0: repeat (n) begin cc = x[31]; x = x << 1; end
      1: repeat (n) begin cc = x[0]; x = x >> 1; end
      2: repeat (n) begin cc = x[0]; x = {x[31], x[31:1]}; end
      default: begin
        if (n != 0 && n % 32 == 0) cc = x[31];
        else if (n % 32 != 0) begin
          repeat (n % 32) x = {x[0], x[31:1]};
          cc = x[31];
        end
      end
    endcase
    return {cc, x};
  endfunction

  function automatic exp_t model(logic [31:0] rm, logic [7:0] rs, logic imm, logic mem,
                                 logic [11:0] so, logic c, logic [3:0] tag);
    exp_t        e;
    logic [31:0] x;
    int          n;
    int          t;
    e.tag = tag; e.ill = 1'b0; e.c = c; e.v = '0;
    if (mem) begin
      e.v = {{20{so[11]}}, so};
    end else if (imm) begin
      x = {24'd0, so[7:0]};
      n = 2 * so[11:8];
      repeat (n) x = {x[0], x[31:1]};
      e.v = x;
      if (n != 0) e.c = x[31];
    end else begin
      t = so[6:5];
      if (!so[4]) begin
        n = so[11:7];
        if (n == 0 && t == 3) begin
          e.v = {c, rm[31:1]};
          e.c = rm[0];
          return e;
        end
        if (n == 0 && (t == 1 || t == 2)) n = 32;
      end else begin
        if (so[7]) begin
          e.ill = 1'b1;
          return e;
        end
        n = rs;
      end
      {e.c, e.v} = bitshift(t, n, rm, c);
    end
    return e;
  endfunction

  task automatic drive_req(logic [31:0] rm, logic [7:0] rs, logic imm, logic mem,
                           logic [11:0] so, logic c, logic [3:0] tag);
    bus.val_rm        = rm;
    bus.val_rs        = {$urandom_range(0, 255), 16'h0, rs};
    bus.imm           = imm;
    bus.is_ldr_or_str = mem;
    bus.shift_operand = so;
    bus.c_in          = c;
    bus.tag_in        = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    drive_req(32'h8000_0001, 8'd1, 1'b0, 1'b1, 12'h800, 1'b1, 4'hA);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b val=%h c=%b ill=%b tag=%h want all 0",
               bus.in_ready, bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    dvec_t tbl[12];
    tbl = '{
      '{32'h8000_0001, 8'd0,  1'b0, 1'b0, 12'h020, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
      '{32'h0000_0003, 8'd0,  1'b0, 1'b0, 12'h060, 1'b1, 32'h8000_0001, 1'b1, 1'b0},
      '{32'h0000_0001, 8'd32, 1'b0, 1'b0, 12'h010, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
      '{32'h0000_0001, 8'd33, 1'b0, 1'b0, 12'h010, 1'b1, 32'h0000_0000, 1'b0, 1'b0},
      '{32'h8000_0000, 8'd64, 1'b0, 1'b0, 12'h070, 1'b0, 32'h8000_0000, 1'b1, 1'b0},
      '{32'h1234_5678, 8'd0,  1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF00_0000, 1'b1, 1'b0},
      '{32'h1234_5678, 8'd0,  1'b0, 1'b1, 12'h800, 1'b1, 32'hFFFF_F800, 1'b1, 1'b0},
      '{32'h1234_5678, 8'd5,  1'b0, 1'b0, 12'h090, 1'b1, 32'h0000_0000, 1'b1, 1'b1},
      '{32'h1234_5678, 8'd0,  1'b1, 1'b0, 12'h0AB, 1'b1, 32'h0000_00AB, 1'b1, 1'b0},
      '{32'h8000_0000, 8'd0,  1'b0, 1'b0, 12'h040, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0},
      '{32'h0000_1234, 8'd0,  1'b0, 1'b0, 12'h000, 1'b1, 32'h0000_1234, 1'b1, 1'b0},
      '{32'hCAFE_F00D, 8'd0,  1'b0, 1'b0, 12'h050, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0}
    };
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_req(tbl[i].rm, tbl[i].rs, tbl[i].imm, tbl[i].mem, tbl[i].so, tbl[i].c, 4'(i));
      bus.in_valid = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d] got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !==
          {1'b1, tbl[i].ev, tbl[i].ec, tbl[i].eill, 4'(i)}) begin
        errors++;
        $display("FAIL directed[%0d] got vld=%b val=%h c=%b ill=%b tag=%h want vld=1 val=%h c=%b ill=%b tag=%h",
                 i, bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out,
                 tbl[i].ev, tbl[i].ec, tbl[i].eill, 4'(i));
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_retire[%0d] got vld=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_stall();
    exp_t        q[$];
    int          acc_n;
    int          idx;
    logic        accept;
    logic [31:0] rms[3];
    logic [11:0] sos[3];
    rms = '{32'h8765_4321, 32'h0000_00F0, 32'h7FFF_FFFF};
    sos = '{12'h0A3, 12'h110, 12'h800};
    acc_n = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      idx = (acc_n < 3) ? acc_n : 2;
      drive_req(rms[idx], 8'd4, 1'b0, (idx == 2), sos[idx], 1'b1, 4'(idx + 1));
      bus.in_valid = 1'b1;
      if (cyc >= 2) begin
        checks++;
        if (bus.in_ready !== 1'b0 || q.size() == 0 ||
            {bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !== {1'b1, q[0]}) begin
          errors++;
          $display("FAIL stall_hold[%0d] got rdy=%b vld=%b val=%h tag=%h want rdy=0 vld=1 head tag=1",
                   cyc, bus.in_ready, bus.out_valid, bus.val2_out, bus.tag_out);
        end
      end
      accept = bus.in_ready;
      @(posedge clk); #1;
      if (accept) begin
        q.push_back(model(rms[idx], 8'd4, 1'b0, (idx == 2), sos[idx], 1'b1, 4'(idx + 1)));
        acc_n++;
      end
    end
    checks++;
    if (acc_n !== 2) begin
      errors++;
      $display("FAIL stall_accept_count got %0d want 2", acc_n);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q.size() == 0 ||
          {bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !== {1'b1, q[0]}) begin
        errors++;
        $display("FAIL stall_drain[%0d] got vld=%b val=%h c=%b tag=%h want tag=%0d in order",
                 k, bus.out_valid, bus.val2_out, bus.carry_out, bus.tag_out, k + 1);
      end
      @(posedge clk); #1;
      if (q.size() != 0) void'(q.pop_front());
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty got vld=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    logic [7:0]  rs_tbl[10];
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        imm, mem, c, acc, ret;
    logic [11:0] so;
    logic [3:0]  tag;
    rs_tbl = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd63, 8'd64, 8'd65, 8'd96, 8'd255};
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL random_flow[%0d] got vld=%b rdy=%b want vld=%b rdy=%b",
                 cyc, bus.out_valid, bus.in_ready, q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) begin
        checks++;
        if ({bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !== q[0]) begin
          errors++;
          $display("FAIL random_data[%0d] got val=%h c=%b ill=%b tag=%h want val=%h c=%b ill=%b tag=%h",
                   cyc, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out,
                   q[0].v, q[0].c, q[0].ill, q[0].tag);
        end
      end
      rm  = ($urandom_range(0, 4) == 0) ? 32'h8000_0001 : 32'($urandom);
      rs  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rs_tbl[$urandom_range(0, 9)];
      mem = ($urandom_range(0, 7) == 0);
      imm = ($urandom_range(0, 5) == 0);
      so  = 12'($urandom);
      if (so[4] && $urandom_range(0, 7) != 0) so[7] = 1'b0;
      c   = 1'($urandom);
      tag = 4'($urandom);
      drive_req(rm, rs, imm, mem, so, c, tag);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus.in_valid && (q.size() < 2);
      ret = bus.out_ready && (q.size() != 0);
      @(posedge clk); #1;
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(model(rm, rs, imm, mem, so, c, tag));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_req(32'h0, 8'd0, 1'b0, 1'b1, 12'h800, 1'b1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill got vld=%b rdy=%b want vld=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out} !== 39'd0) begin
      errors++;
      $display("FAIL flush_reset got rdy=%b vld=%b val=%h c=%b ill=%b tag=%h want all 0",
               bus.in_ready, bus.out_valid, bus.val2_out, bus.carry_out, bus.illegal, bus.tag_out);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %b want 1", bus.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale[%0d] got vld=%b tag=%h want vld=0", k, bus.out_valid, bus.tag_out);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_req(32'h0, 8'd0, 1'b0, 1'b0, 12'h0, 1'b0, 4'h0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
